uart_tx: RTL and testbench

- UART transmitter directly downstream of the 1x baud tick generator.
- Consumes the one-clock-wide baud_tick pulse (one per bit period) and serialises a parallel byte onto the tx line.
- Frame: start bit, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
- Sits between the command/FIFO logic (tx_start/tx_data) and the board TX pin.

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises a parallel word onto tx, one bit per baud_tick,
// with the start bit aligned to the tick grid, optional parity and 1 or 2 stop bits.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state and registered-output logic; every transition past IDLE waits for a tick.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ 1'(PARITY_ODD);
                    busy_d   = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) on a shared
// 10-clk baud tick; each frame is checked bit by bit for level and exact duration.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] start;
    logic [7:0] data [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // One-clk tick every 10 clk, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst_n), .baud_tick(tick), .tx_start(start[0]), .tx_data(data[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst_n), .baud_tick(tick), .tx_start(start[1]), .tx_data(data[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst_n), .baud_tick(tick), .tx_start(start[2]), .tx_data(data[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst_n), .baud_tick(tick), .tx_start(start[3]), .tx_data(data[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected line levels, bit 0 = start bit; parity value supplied by the caller.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit par_en,
                                               input bit par, input int stops, output int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[1+i] = d[i];
        n = 9;
        if (par_en) begin
            v[n] = par;
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            v[n] = 1'b1;
            n++;
        end
        return v;
    endfunction

    task automatic send(input int d, input logic [7:0] v);
        data[d]  = v;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_fall(input int d, input int budget, output int lat);
        lat = 0;
        while (tx_w[d] !== 1'b0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Leaves the caller on the negedge of the tx_done cycle.
    task automatic check_frame(input int d, input string tag, input logic [7:0] v,
                               input bit par_en, input bit par, input int stops,
                               input int budget, output int lat);
        logic [15:0] bits;
        int          n;
        bit          ok;
        bits = frame_bits(v, par_en, par, stops, n);
        wait_fall(d, budget, lat);
        if (tx_w[d] !== 1'b0) begin
            chk($sformatf("%s_start_timeout", tag), 32'(tx_w[d]), 32'd0);
            return;
        end
        for (int j = 0; j < n; j++) begin
            ok = 1'b1;
            for (int s = 0; s < 10; s++) begin
                if (tx_w[d] !== bits[j] || busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, j), 32'(ok), 32'd1);
        end
        chk($sformatf("%s_done", tag), 32'(done_w[d]), 32'd1);
        chk($sformatf("%s_busy_at_done", tag), 32'(busy_w[d]), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx%0d", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("reset_done%0d", i), 32'(done_w[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0x55: alternating levels, then a single-cycle tx_done.
        send(0, 8'h55);
        chk("busy_after_accept", 32'(busy_w[0]), 32'd1);
        check_frame(0, "n1_55", 8'h55, 1'b0, 1'b0, 1, 20, lat);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_w[0]), 32'd0);
        chk("idle_tx_high", 32'(tx_w[0]), 32'd1);

        // 0xA3 has four ones: even parity bit 0, odd parity bit 1.
        send(1, 8'hA3);
        check_frame(1, "e1_A3", 8'hA3, 1'b1, 1'b0, 1, 20, lat);
        send(2, 8'hA3);
        check_frame(2, "o1_A3", 8'hA3, 1'b1, 1'b1, 1, 20, lat);

        send(3, 8'h00);
        check_frame(3, "n2_00", 8'h00, 1'b0, 1'b0, 2, 20, lat);

        // tx_start held through a busy frame; new data only taken in the tx_done cycle.
        data[0]  = 8'h12;
        start[0] = 1'b1;
        @(negedge clk);
        data[0] = 8'hFF;
        check_frame(0, "hold_12", 8'h12, 1'b0, 1'b0, 1, 20, lat);
        data[0] = 8'h0F;
        @(negedge clk);
        start[0] = 1'b0;
        check_frame(0, "b2b_0F", 8'h0F, 1'b0, 1'b0, 1, 12, lat);
        chk("b2b_latency", 32'(lat), 32'd9);
        @(negedge clk);

        // Reset in the middle of data bit 3 aborts the frame.
        send(0, 8'hA5);
        wait_fall(0, 20, lat);
        chk("abort_start_seen", 32'(tx_w[0]), 32'd0);
        repeat (45) @(negedge clk);
        chk("abort_pre_bit3", 32'(tx_w[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_tx", 32'(tx_w[0]), 32'd1);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        send(0, 8'hC3);
        check_frame(0, "after_abort_C3", 8'hC3, 1'b0, 1'b0, 1, 20, lat);
        @(negedge clk);

        // tx_start coinciding with a tick: that tick is ignored, start bit on the next one.
        data[0] = 8'h3C;
        @(posedge tick);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check_frame(0, "same_tick_3C", 8'h3C, 1'b0, 1'b0, 1, 20, lat);
        chk("same_tick_latency", 32'(lat), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
